// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Requester side of the instruction-memory interface. This block owns the PC,
// drives it to a combinational read-only instruction memory, and captures the
// returned words into a small prefetch FIFO. The head FIFO entry is presented
// to the IF/ID boundary as {instruction, PC, PC+4} over a valid/ready
// handshake. Redirects from later stages flush the FIFO and restart fetch.
//
// Parameters:
//   RESET_PC  PC loaded on reset (word-aligned)
//   DEPTH     prefetch FIFO entries (power of two, 2..16)
//
// Ports:
//   Clk            in   clock, rising-edge
//   Reset          in   synchronous active-high reset
//   Address        out  [31:0] byte address to memory (the PC register)
//   Instruction    in   [31:0] word returned by memory for Address
//   redirect_valid in   restart fetch at redirect_pc this cycle
//   redirect_pc    in   [31:0] redirect target (bits [1:0] cleared)
//   out_valid      out  head FIFO entry is valid
//   out_ready      in   consumer accepts head entry
//   out_instr      out  [31:0] head instruction (0 when empty)
//   out_pc         out  [31:0] head PC (0 when empty)
//   out_pc_plus4   out  [31:0] head PC + 4 (0 when empty)
//   align_err      out  sticky misaligned-redirect flag
//   fetch_count    out  [31:0] FIFO pushes since reset
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        align_err,
  output logic [31:0] fetch_count
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    L_DEPTH = (AW+1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic          r_align_err;
  logic [31:0]   r_fetch_count;

  // FIFO storage is data only; it is never reset, emptiness is tracked by r_count.
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic          w_fetch_en;
  logic          w_push;
  logic [31:0]   w_head_instr;
  logic [31:0]   w_head_pc;

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && out_ready;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign w_fetch_en = (r_count < L_DEPTH) || w_pop;
  assign w_push     = w_fetch_en && !redirect_valid;

  assign w_head_instr = r_fifo_instr[r_head];
  assign w_head_pc    = r_fifo_pc[r_head];

  // Address comes straight from the PC register: no path from out_ready.
  assign Address      = r_pc;
  assign out_valid    = w_valid;
  assign out_instr    = w_valid ? w_head_instr : 32'd0;
  assign out_pc       = w_valid ? w_head_pc    : 32'd0;
  assign out_pc_plus4 = w_valid ? (w_head_pc + 32'd4) : 32'd0;
  assign align_err    = r_align_err;
  assign fetch_count  = r_fetch_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc          <= RESET_PC;
      r_count       <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_align_err   <= 1'b0;
      r_fetch_count <= 32'd0;
    end else if (redirect_valid) begin
      // Redirect flushes everything, including an entry popped this cycle.
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        r_align_err <= 1'b1;
      end
    end else begin
      if (w_push) begin
        r_pc          <= r_pc + 32'd4;
        r_tail        <= r_tail + 1'b1;
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo_instr[r_tail] <= Instruction;
      r_fifo_pc[r_tail]    <= r_pc;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the instruction-memory interface: owns the PC and drives the 32-bit byte address to the combinational, read-only instruction memory.
- Captures the returned instruction word into a small prefetch FIFO.
- Presents {instruction, PC, PC+4} to the IF/ID boundary over a valid/ready handshake.
- Accepts branch/jump redirects from later stages, which flush the FIFO.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
DEPTH, 4, prefetch FIFO entries; power of two, 2..16.

Ports:
Clk  input  1  single clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Address  output  32  byte address to instruction memory; equals PC register, bits[1:0] always 0.
Instruction  input  32  word returned combinationally by memory for Address in the same cycle.
redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
redirect_pc  input  32  redirect target; bits[1:0] ignored/cleared.
out_valid  output  1  head FIFO entry is valid.
out_ready  input  1  consumer accepts head entry this cycle.
out_instr  output  32  instruction of head entry.
out_pc  output  32  PC of head entry.
out_pc_plus4  output  32  out_pc + 4, mod 2^32.
align_err  output  1  sticky; set when a redirect arrives with redirect_pc[1:0] != 0.
fetch_count  output  32  number of FIFO pushes since reset; wraps mod 2^32.

Behaviour:
Reset:
- Synchronous, priority over everything.
- PC=RESET_PC, FIFO empty (count=0, pointers=0), align_err=0, fetch_count=0.
- out_valid=0; out_instr, out_pc, out_pc_plus4 read 0 while empty.

Handshake and fetch:
- pop = out_valid && out_ready.
- fetch_en = (count < DEPTH) || pop.
- push = fetch_en && !redirect_valid.
- On push:
  - Write {Instruction, PC} at tail.
  - PC <= PC + 4 (wraps 32'hFFFF_FFFC -> 0).
  - fetch_count++.
- When not pushing, the PC holds. Address is always driven from the PC register, with no combinational path from out_ready.
- Latency: word fetched at cycle N appears on out_* with out_valid=1 at N+1.
- With out_ready held high: sustained throughput of one instruction per cycle.
- Full FIFO with a simultaneous pop: push is still allowed and count is unchanged.
- out_* are driven from the head slot (FIFO storage read combinationally from the head pointer). The head entry is stable while out_valid && !out_ready.
- count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - Never exceeds DEPTH; never underflows. Pop while empty is impossible since out_valid=0.

Redirect:
- Priority over push and pop.
- Next cycle: count=0, pointers=0, PC = {redirect_pc[31:2], 2'b00}.
- No push in the redirect cycle.
- A pop coinciding with redirect_valid is legal; that entry is discarded with the rest, because the consumer is flushing too.
- out_valid=0 in the cycle after the redirect. The first target instruction appears in the cycle after that.
- Back-to-back redirects: the last one wins; the FIFO stays empty.
- If redirect_pc[1:0] != 0: align_err <= 1, held until Reset. Fetch proceeds from the aligned address.

Reset mid-operation:
- Discards all entries and restarts at RESET_PC.
- Reset dominates a simultaneous redirect_valid.

Memory range:
- Address is not range-checked here. Memory indexing and wrap are the memory's responsibility.

Test Plan:
1. Reset with RESET_PC=0, then out_ready=1, memory word[i]=i*3 -> out_valid first rises one cycle after reset deasserts. out_pc=0,4,8,12 on consecutive cycles; out_instr=0,3,6,9; out_pc_plus4=4,8,12,16.
2. out_ready=0 for 8 cycles (DEPTH=4) -> exactly 4 pushes, Address frozen at 16, fetch_count=4, head holds out_pc=0. Then out_ready=1 -> out_pc 0,4,8,12,16,... with no gaps or duplicates.
3. Full FIFO, redirect_valid=1 with redirect_pc=0x40 and out_ready=1 in the same cycle -> next cycle out_valid=0, Address=0x40. Following cycle out_pc=0x40, out_instr=mem[16]=48. No stale entries are emitted.
4. Redirect to 0x102 -> align_err=1 (and remains 1 afterwards), fetch resumes at 0x100, out_pc=0x100.
5. Redirect to 0xFFFF_FFFC with out_ready=1 -> out_pc=0xFFFF_FFFC with out_pc_plus4=0, then out_pc=0. No stall occurs at the wrap.
6. Reset asserted for one cycle mid-stream with FIFO half full and redirect_valid=1 -> next cycle out_valid=0, fetch_count=0, align_err=0, Address=RESET_PC. The stream restarts from RESET_PC.
